// File: rtl/fetch_queue_pkg.sv
// Shared widths, reset constants and the FIFO entry layout for the fetch front end.
package fetch_queue_pkg;
  localparam int INST_W = 32;
  localparam int ADDR_W = 32;
  localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [INST_W-1:0] NOP = 32'h0000_0000;

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [ADDR_W-1:0] pcplus4;
  } fq_entry_t;

  function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] pc);
    return pc >> 2;
  endfunction
endpackage

// File: rtl/fetch_queue_fifo.sv
// DEPTH-entry FIFO of {inst, pcplus4}. The head is readable in the same cycle, and clear takes priority.
// There is no internal backpressure: the producer must not push when the FIFO is full.
module fetch_queue_fifo
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     push,
  input  fq_entry_t                push_dat,
  input  logic                     pop,
  output fq_entry_t                head_dat,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fq_entry_t     mem_q [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '{inst: NOP, pcplus4: '0};
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr] <= push_dat;
        wr_ptr        <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  assign head_dat = mem_q[rd_ptr];
endmodule

// File: rtl/fetch_queue.sv
// Fetch PC owner. It issues credit-checked IMEM reads and buffers {inst, pc+4} for IF/ID, and a redirect flushes it.
// Request-to-dec_valid latency is 2 cycles. A read is issued only when a FIFO slot is reserved for its response.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   redirect_en,
  input  logic [ADDR_W-1:0]      redirect_pc,
  output logic                   imem_req,
  output logic [ADDR_W-1:0]      imem_addr,
  input  logic [INST_W-1:0]      imem_rdata,
  output logic                   dec_valid,
  input  logic                   dec_ready,
  output logic [INST_W-1:0]      dec_inst,
  output logic [ADDR_W-1:0]      dec_pcplus4,
  output logic [$clog2(DEPTH):0] fq_count
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] tag_q;
  logic              inflight_q;
  logic [CW-1:0]     used;
  logic              push;
  logic              pop;
  fq_entry_t         push_dat;
  fq_entry_t         head_dat;

  // Buffered entries plus the outstanding read must leave room for one more response.
  assign used      = fq_count + CW'(inflight_q);
  assign imem_req  = rst_n & ~redirect_en & (used < DEPTH_C);
  assign imem_addr = imem_req ? word_addr(pc_q) : '0;

  assign push      = inflight_q & ~redirect_en;
  assign push_dat  = '{inst: imem_rdata, pcplus4: tag_q};
  assign dec_valid = (fq_count != '0) & ~redirect_en;
  assign pop       = dec_valid & dec_ready;

  assign dec_inst    = head_dat.inst;
  assign dec_pcplus4 = head_dat.pcplus4;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      tag_q      <= '0;
      inflight_q <= 1'b0;
    end else if (redirect_en) begin
      pc_q       <= redirect_pc & ~ADDR_W'(3);
      inflight_q <= 1'b0;
    end else if (imem_req) begin
      pc_q       <= pc_q + ADDR_W'(4);
      tag_q      <= pc_q + ADDR_W'(4);
      inflight_q <= 1'b1;
    end else begin
      inflight_q <= 1'b0;
    end
  end

  fetch_queue_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (redirect_en),
    .push     (push),
    .push_dat (push_dat),
    .pop      (pop),
    .head_dat (head_dat),
    .count    (fq_count)
  );
endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue. It uses a directed vector table plus a randomized run against a PC-sequence model.
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  localparam int          DEPTH  = 4;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk;
  logic        rst_n;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_inst;
  logic [31:0] dec_pcplus4;
  logic [2:0]  fq_count;

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .redirect_en (redirect_en),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .dec_valid   (dec_valid),
    .dec_ready   (dec_ready),
    .dec_inst    (dec_inst),
    .dec_pcplus4 (dec_pcplus4),
    .fq_count    (fq_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Instruction memory contents: mem[w] = w + 1.
  function automatic logic [31:0] mem_f(input logic [31:0] w);
    return w + 32'd1;
  endfunction

  logic        s_req, s_valid;
  logic [31:0] s_addr, s_inst, s_pc4, pend;
  logic [2:0]  s_cnt;

  // One clock cycle. Inputs are driven just after the edge and outputs are sampled mid-cycle.
  // The read response is presented in the following cycle.
  task automatic cycle(input logic re, input logic [31:0] rpc, input logic rdy);
    redirect_en = re;
    redirect_pc = rpc;
    dec_ready   = rdy;
    #4;
    s_req   = imem_req;
    s_addr  = imem_addr;
    s_valid = dec_valid;
    s_inst  = dec_inst;
    s_pc4   = dec_pcplus4;
    s_cnt   = fq_count;
    pend    = s_req ? mem_f(s_addr) : (32'hDEAD_0000 ^ 32'($urandom_range(0, 255)));
    @(posedge clk);
    #1;
    imem_rdata = pend;
  endtask

  task automatic chk_zero(input string pfx);
    chk({pfx, " req"},   32'(imem_req),  32'd0);
    chk({pfx, " addr"},  imem_addr,      32'd0);
    chk({pfx, " valid"}, 32'(dec_valid), 32'd0);
    chk({pfx, " inst"},  dec_inst,       32'd0);
    chk({pfx, " pc4"},   dec_pcplus4,    32'd0);
    chk({pfx, " cnt"},   32'(fq_count),  32'd0);
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    redirect_en = 1'b0;
    redirect_pc = '0;
    dec_ready   = 1'b0;
    imem_rdata  = '0;
    #1;
    chk_zero("reset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic        rst;
    logic        re;
    logic [31:0] rpc;
    logic        rdy;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] inst;
    logic [31:0] pc4;
    int          cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic v(input logic rst, input logic re, input logic [31:0] rpc, input logic rdy,
                   input logic req, input logic [31:0] addr, input logic valid,
                   input logic [31:0] inst, input logic [31:0] pc4, input int cnt);
    vecs.push_back('{rst, re, rpc, rdy, req, addr, valid, inst, pc4, cnt});
  endtask

  logic [31:0] exp_pc, rpc;
  logic        re, rdy, restart;
  int          idle, max_idle, delivered;

  initial begin
    rst_n = 1'b0;
    // Streaming with the consumer always ready.
    v(1,0,0,1, 1,0, 0,0,0, 0);
    v(0,0,0,1, 1,1, 0,0,0, 0);
    v(0,0,0,1, 1,2, 1,1,4, 1);
    v(0,0,0,1, 1,3, 1,2,8, 1);
    v(0,0,0,1, 1,4, 1,3,12, 1);
    // Consumer stalled: exactly DEPTH requests, then drain and resume at word 4.
    v(1,0,0,0, 1,0, 0,0,0, 0);
    v(0,0,0,0, 1,1, 0,0,0, 0);
    v(0,0,0,0, 1,2, 1,1,4, 1);
    v(0,0,0,0, 1,3, 1,1,4, 2);
    v(0,0,0,0, 0,0, 1,1,4, 3);
    v(0,0,0,0, 0,0, 1,1,4, 4);
    v(0,0,0,0, 0,0, 1,1,4, 4);
    v(0,0,0,1, 0,0, 1,1,4, 4);
    v(0,0,0,1, 1,4, 1,2,8, 3);
    v(0,0,0,1, 1,5, 1,3,12, 2);
    v(0,0,0,1, 1,6, 1,4,16, 2);
    v(0,0,0,1, 1,7, 1,5,20, 2);
    // Redirect with 3 buffered entries, a read in flight, and a pop offered in the same cycle.
    v(1,0,0,0, 1,0, 0,0,0, 0);
    v(0,0,0,0, 1,1, 0,0,0, 0);
    v(0,0,0,0, 1,2, 1,1,4, 1);
    v(0,0,0,0, 1,3, 1,1,4, 2);
    v(0,1,32'h100,1, 0,0, 0,0,0, 3);
    v(0,0,0,1, 1,32'h40, 0,0,0, 0);
    v(0,0,0,1, 1,32'h41, 0,0,0, 0);
    v(0,0,0,1, 1,32'h42, 1,32'h41,32'h104, 1);
    // Second redirect to a misaligned target; the low address bits are dropped.
    v(0,1,32'h203,1, 0,0, 0,0,0, 1);
    v(0,0,0,1, 1,32'h80, 0,0,0, 0);
    v(0,0,0,1, 1,32'h81, 0,0,0, 0);
    v(0,0,0,1, 1,32'h82, 1,32'h81,32'h204, 1);

    foreach (vecs[i]) begin
      if (vecs[i].rst) do_reset();
      cycle(vecs[i].re, vecs[i].rpc, vecs[i].rdy);
      chk($sformatf("v%0d req", i), 32'(s_req), 32'(vecs[i].req));
      if (vecs[i].req) chk($sformatf("v%0d addr", i), s_addr, vecs[i].addr);
      chk($sformatf("v%0d valid", i), 32'(s_valid), 32'(vecs[i].valid));
      if (vecs[i].valid) begin
        chk($sformatf("v%0d inst", i), s_inst, vecs[i].inst);
        chk($sformatf("v%0d pc4", i), s_pc4, vecs[i].pc4);
      end
      chk($sformatf("v%0d cnt", i), 32'(s_cnt), 32'(vecs[i].cnt));
    end

    // Randomized run. The model is the next PC owed to decode, in program order.
    do_reset();
    exp_pc    = RST_PC;
    idle      = 0;
    max_idle  = 0;
    delivered = 0;
    restart   = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      re  = ($urandom_range(0, 24) == 0);
      rpc = $urandom;
      if (c == 300) begin
        re  = 1'b1;
        rpc = 32'hFFFF_FFF9;
      end
      rdy = (c % 200 < 100) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      cycle(re, rpc, rdy);

      if (restart) begin
        chk("restart req", 32'(s_req), 32'd1);
        chk("restart addr", s_addr, RST_PC >> 2);
        restart = 1'b0;
      end
      if (s_valid && rdy) begin
        chk("rnd inst", s_inst, mem_f(exp_pc >> 2));
        chk("rnd pc4", s_pc4, exp_pc + 32'd4);
        exp_pc = exp_pc + 32'd4;
        delivered++;
      end
      if (re) begin
        chk("rnd redirect valid", 32'(s_valid), 32'd0);
        chk("rnd redirect req", 32'(s_req), 32'd0);
        exp_pc = rpc & ~32'd3;
      end
      chk("rnd count bound", 32'(s_cnt <= 3'(DEPTH)), 32'd1);
      if (re || !rdy || s_valid) idle = 0;
      else idle++;
      if (idle > max_idle) max_idle = idle;

      if (c == 700) begin
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("async reset");
        @(posedge clk);
        #1;
        rst_n      = 1'b1;
        imem_rdata = '0;
        exp_pc     = RST_PC;
        idle       = 0;
        restart    = 1'b1;
      end
    end
    chk("rnd max idle", 32'(max_idle <= 2), 32'd1);
    chk("rnd delivered", 32'(delivered > 200), 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
